cpu_bus: RTL and testbench
==========================

# cpu_bus

Address decoder and transaction sequencer sitting directly downstream of `cpu`. It consumes the CPU's address/data/valid outputs, routes each access to internal work RAM, the PPU register port, or the PRG ROM port, and returns read data with a level `data_valid` the CPU samples on its next divided clock tick. Unmapped reads return open-bus data.

## Interface
- `RAM_ADDR_WIDTH`, 11: internal work RAM depth (2 KiB), mirrored across $0000-$1FFF.
- `PRG_16K`, 0: 1 means PRG ROM is 16 KiB, so `prg_address_o[14]` is forced to 0 (mirror at $C000).
- `TIMEOUT_CYCLES`, 8: maximum cycles to wait for an external ack before abandoning the access. Must be less than the CPU `CLOCK_DIVIDER` minus 3.
- `clock_i` input 1: system clock; single clock domain.
- `reset_i` input 1: synchronous, active-high reset.
- `cpu_tick_i` input 1: one-cycle pulse, high on the same edge the CPU updates its registers (its divided clock enable).
- `cpu_address_i` input 16: CPU `address_o`.
- `cpu_address_valid_i` input 1: CPU `address_valid_o`.
- `cpu_write_i` input 1: CPU `data_valid_o`; 1 = write, 0 = read.
- `cpu_wdata_i` input 8: CPU `data_o`.
- `cpu_rdata_o` output 8: read data to CPU `data_i`; also the open-bus latch.
- `cpu_data_valid_o` output 1: to CPU `data_valid_i`; level signal.
- `ppu_addr_o` output 3, `ppu_wdata_o` output 8, `ppu_read_o` output 1, `ppu_write_o` output 1: PPU register request.
- `ppu_rdata_i` input 8, `ppu_ack_i` input 1: PPU response.
- `prg_address_o` output 15, `prg_request_o` output 1: PRG ROM read request.
- `prg_data_i` input 8, `prg_ack_i` input 1: PRG response.
- `bus_error_o` output 1: sticky; set on a timeout or on an overlapping tick. Cleared only by reset.

## Operation
- Pending flag: set by reset and by every `cpu_tick_i`. A transaction launches on the first edge where pending=1, the FSM is in IDLE, and `cpu_address_valid_i`=1. Pending clears at launch.
- At launch, capture the address, write flag and write data, and drop `cpu_data_valid_o` to 0.
- Decode, using the captured address `A`:
  - $0000-$1FFF: RAM at index `A[RAM_ADDR_WIDTH-1:0]`.
  - $2000-$3FFF: PPU register at `A[2:0]`.
  - $4000-$7FFF: unmapped.
  - $8000-$FFFF: PRG at `A[14:0]`, with bit 14 forced to 0 when `PRG_16K`.
- FSM states: IDLE, RAM, PPU, PRG, DONE.
  - IDLE -> RAM, PPU or PRG at launch.
  - IDLE -> DONE directly for unmapped accesses and for PRG writes. Reads return `cpu_rdata_o` unchanged (open bus); writes are discarded.
  - RAM -> DONE after exactly 1 cycle. A read registers the RAM output into `cpu_rdata_o`; a write stores `cpu_wdata_i` and copies it into `cpu_rdata_o`.
  - PPU / PRG -> DONE on the edge where ack=1 while the request is high.
    - Reads load `cpu_rdata_o` from the target's data.
    - PPU writes load `cpu_rdata_o` with the write data.
  - DONE -> IDLE when the next launch occurs. `cpu_data_valid_o` is 1 throughout DONE.
- External handshake:
  - Request, address and write data assert on the launch edge and stay stable while the request is high.
  - Request drops on the edge ack is sampled.
  - Ack is ignored while the request is low.
- Timeout: if `TIMEOUT_CYCLES` cycles elapse in PPU or PRG without ack:
  - drop the request;
  - set `bus_error_o`;
  - go to DONE with `cpu_rdata_o` unchanged.
- Overlapping tick: if `cpu_tick_i` arrives while in RAM, PPU or PRG:
  - abort the access (request low, no RAM write);
  - set `bus_error_o`;
  - go to IDLE, with pending set so the new address launches next.
- `cpu_address_valid_i`=0 with pending set: hold in IDLE until it rises.

## Timing
- Reset values:
  - `cpu_rdata_o`=0, `cpu_data_valid_o`=0.
  - All request strobes and `ppu_addr_o`/`ppu_wdata_o`/`prg_address_o` = 0.
  - `bus_error_o`=0, FSM=IDLE, pending=1.
  - RAM contents are not reset.
- Reset asserted mid-transaction aborts it; request strobes are low on the cycle after the reset edge.
- Latency is counted from the tick edge T:
  - launch at T+1;
  - RAM / unmapped / PRG-write valid at T+2 (unmapped and PRG-write go straight to DONE at launch);
  - external access valid at T+1+k, where k = ack cycle count (1 if ack is returned the cycle after request).
- Worst case is T+1+`TIMEOUT_CYCLES`. This always precedes the next tick, so the CPU sees valid data.
- Address wrap: $FFFF decodes to PRG `A[14:0]`=$7FFF; $1FFF decodes to RAM $7FF.

## Test plan
- Reset, `cpu_address_i`=$FFFC, PRG returns $34 with ack 2 cycles after request: `prg_address_o`=$7FFC, `cpu_rdata_o`=$34, valid at T+3; `bus_error_o`=0.
- Write $5A to $0801 (tick), then read $1801 (tick): the read returns $5A 2 cycles after its tick (RAM mirror).
- Write $80 to $2000, then read $3FFA with `ppu_rdata_i`=$C3 and immediate ack:
  - write: `ppu_addr_o`=0, `ppu_write_o` pulses once;
  - read: `ppu_addr_o`=2, `cpu_rdata_o`=$C3.
- Read $4017 after a PRG read of $A9: `cpu_rdata_o` stays $A9 and valid at T+2; no request strobe fires.
- PRG read with ack never asserted (`TIMEOUT_CYCLES`=8): `prg_request_o` high for exactly 8 cycles; valid at T+9 with open-bus data; `bus_error_o`=1.
- `PRG_16K`=1, read $C005: `prg_address_o`=$0005. Reset pulse during a PRG wait: `prg_request_o`=0 the next cycle and `bus_error_o`=0.

Source files
------------

// File: rtl/cpu_bus_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_if
//   Bundles every signal cpu_bus exchanges with the outside world:
//   - the CPU side: tick, address, valid, write data, read data and data_valid
//   - the PPU register port: address, data, read/write strobes and ack
//   - the PRG ROM port: address, request and ack
//   - the sticky bus error flag
//   The slave modport is the view of cpu_bus itself. The master modport is the
//   view of whatever drives it (CPU plus PPU/PRG responders).
// -----------------------------------------------------------------------------
interface cpu_bus_if;
    // CPU side
    logic        tick;
    logic [15:0] address;
    logic        address_valid;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        data_valid;

    // PPU register port
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_read;
    logic        ppu_write;
    logic [7:0]  ppu_rdata;
    logic        ppu_ack;

    // PRG ROM port
    logic [14:0] prg_address;
    logic        prg_request;
    logic [7:0]  prg_data;
    logic        prg_ack;

    // Status
    logic        bus_error;

    modport slave (
        input  tick, address, address_valid, write, wdata,
        input  ppu_rdata, ppu_ack, prg_data, prg_ack,
        output rdata, data_valid,
        output ppu_addr, ppu_wdata, ppu_read, ppu_write,
        output prg_address, prg_request,
        output bus_error
    );

    modport master (
        output tick, address, address_valid, write, wdata,
        output ppu_rdata, ppu_ack, prg_data, prg_ack,
        input  rdata, data_valid,
        input  ppu_addr, ppu_wdata, ppu_read, ppu_write,
        input  prg_address, prg_request,
        input  bus_error
    );
endinterface

// File: rtl/cpu_bus.sv
// -----------------------------------------------------------------------------
// cpu_bus
//   Address decoder and transaction sequencer behind the CPU. Each CPU tick
//   arms one access; the access is routed to work RAM ($0000-$1FFF, mirrored),
//   the PPU register port ($2000-$3FFF, mirrored every 8 bytes) or the PRG ROM
//   port ($8000-$FFFF). $4000-$7FFF is unmapped and reads return the last
//   value on the bus (open bus). Read data is returned with a level data_valid.
//
// Ports
//   clk  : system clock, single domain
//   rst  : synchronous, active-high reset
//   bus  : cpu_bus_if.slave (CPU request/response, PPU and PRG ports, error)
//
// Parameters
//   RAM_ADDR_WIDTH : log2 of work RAM depth
//   PRG_16K        : 1 forces prg_address[14] to 0 (16 KiB ROM mirrored)
//   TIMEOUT_CYCLES : cycles to wait for an external ack before giving up
// -----------------------------------------------------------------------------
module cpu_bus #(
    parameter int RAM_ADDR_WIDTH = 11,
    parameter bit PRG_16K        = 1'b0,
    parameter int TIMEOUT_CYCLES = 8
) (
    input logic      clk,
    input logic      rst,
    cpu_bus_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RAM, PPU, PRG, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                    state;
    state_t                    launch_state;
    logic                      pending;
    logic                      launch;
    logic                      ext_ack;
    logic                      timeout;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx_q;
    logic                      write_q;
    logic [7:0]                wdata_q;
    logic [CNT_W-1:0]          wait_cnt;
    logic [7:0]                ram [0:(1 << RAM_ADDR_WIDTH) - 1];

    // Target selection from the live CPU address; only used on the launch edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        launch_state = DONE;
        if (bus.address[15])
            launch_state = bus.write ? DONE : PRG;  // ROM writes are dropped
        else if (bus.address[14])
            launch_state = DONE;                    // unmapped
        else if (bus.address[13])
            launch_state = PPU;
        else
            launch_state = RAM;
    end

    // DONE doubles as the idle state that still presents valid read data, so
    // a new access may launch straight out of it.
    assign launch  = pending && bus.address_valid && (state == IDLE || state == DONE);
    assign ext_ack = (state == PPU && bus.ppu_ack && (bus.ppu_read || bus.ppu_write)) ||
                     (state == PRG && bus.prg_ack && bus.prg_request);
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: the RAM array has no reset; it lives in its own clocked block so
    // it still maps onto a plain memory without a reset port.
    always_ff @(posedge clk) begin
        if (!rst && state == RAM && write_q && !bus.tick)
            ram[ram_idx_q] <= wdata_q;
    end

    // NOTE: all state in clocked blocks uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= 1'b1;
            ram_idx_q       <= '0;
            write_q         <= 1'b0;
            wdata_q         <= '0;
            wait_cnt        <= '0;
            bus.rdata       <= '0;
            bus.data_valid  <= 1'b0;
            bus.ppu_addr    <= '0;
            bus.ppu_wdata   <= '0;
            bus.ppu_read    <= 1'b0;
            bus.ppu_write   <= 1'b0;
            bus.prg_address <= '0;
            bus.prg_request <= 1'b0;
            bus.bus_error   <= 1'b0;
        end else begin
            // A tick always re-arms; it wins over the clear at launch so an
            // address presented on the same edge is not lost.
            if (bus.tick)
                pending <= 1'b1;
            else if (launch)
                pending <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state          <= launch_state;
                        ram_idx_q      <= bus.address[RAM_ADDR_WIDTH-1:0];
                        write_q        <= bus.write;
                        wdata_q        <= bus.wdata;
                        wait_cnt       <= '0;
                        bus.data_valid <= 1'b0;
                        case (launch_state)
                            PPU: begin
                                bus.ppu_addr  <= bus.address[2:0];
                                bus.ppu_wdata <= bus.wdata;
                                bus.ppu_write <= bus.write;
                                bus.ppu_read  <= !bus.write;
                            end
                            PRG: begin
                                bus.prg_address <= {bus.address[14] & !PRG_16K, bus.address[13:0]};
                                bus.prg_request <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (state == DONE) begin
                        bus.data_valid <= 1'b1;
                    end
                end

                RAM: begin
                    if (bus.tick) begin
                        state         <= IDLE;
                        bus.bus_error <= 1'b1;
                    end else begin
                        state          <= DONE;
                        bus.data_valid <= 1'b1;
                        bus.rdata      <= write_q ? wdata_q : ram[ram_idx_q];
                    end
                end

                PPU, PRG: begin
                    if (bus.tick) begin
                        // CPU moved on before the access finished: abandon it.
                        state           <= IDLE;
                        bus.bus_error   <= 1'b1;
                        bus.ppu_read    <= 1'b0;
                        bus.ppu_write   <= 1'b0;
                        bus.prg_request <= 1'b0;
                    end else if (ext_ack) begin
                        state           <= DONE;
                        bus.data_valid  <= 1'b1;
                        bus.ppu_read    <= 1'b0;
                        bus.ppu_write   <= 1'b0;
                        bus.prg_request <= 1'b0;
                        if (state == PPU)
                            bus.rdata <= write_q ? wdata_q : bus.ppu_rdata;
                        else
                            bus.rdata <= bus.prg_data;
                    end else if (timeout) begin
                        // Give up; rdata keeps its open-bus value.
                        state           <= DONE;
                        bus.data_valid  <= 1'b1;
                        bus.bus_error   <= 1'b1;
                        bus.ppu_read    <= 1'b0;
                        bus.ppu_write   <= 1'b0;
                        bus.prg_request <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus
//   Self-checking bench for cpu_bus. A table of per-cycle records drives the
//   CPU/PPU/PRG inputs and lists the outputs expected after that clock edge;
//   hand-written sequences cover reset, timeout, reset mid-wait, overlapping
//   ticks and the 16 KiB PRG mirror (second instance with PRG_16K=1).
// -----------------------------------------------------------------------------
module tb_cpu_bus;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_bus_if bus ();
    cpu_bus_if b16 ();

    cpu_bus #(.RAM_ADDR_WIDTH(11), .PRG_16K(1'b0), .TIMEOUT_CYCLES(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_bus #(.RAM_ADDR_WIDTH(11), .PRG_16K(1'b1), .TIMEOUT_CYCLES(8)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tick, av, wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        ppu_ack;
        logic [7:0]  ppu_rdata;
        logic        prg_ack;
        logic [7:0]  prg_data;
        logic [7:0]  e_rdata;
        logic        e_valid, e_ppu_rd, e_ppu_wr;
        logic [2:0]  e_ppu_addr;
        logic        e_prg_req;
        logic [14:0] e_prg_addr;
        logic        e_err;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic t, av, wr, input logic [15:0] a, input logic [7:0] wd,
        input logic pack, input logic [7:0] prd, input logic gack, input logic [7:0] grd,
        input logic [7:0] er, input logic ev, erd, ewr, input logic [2:0] epa,
        input logic egr, input logic [14:0] ega, input logic eerr);
        vec_t v;
        v.tick = t;   v.av = av;   v.wr = wr;   v.addr = a;   v.wdata = wd;
        v.ppu_ack = pack;  v.ppu_rdata = prd;  v.prg_ack = gack;  v.prg_data = grd;
        v.e_rdata = er;    v.e_valid = ev;     v.e_ppu_rd = erd;  v.e_ppu_wr = ewr;
        v.e_ppu_addr = epa; v.e_prg_req = egr; v.e_prg_addr = ega; v.e_err = eerr;
        return v;
    endfunction

    task automatic drive_idle();
        bus.tick = 1'b0;      bus.address = 16'h0000; bus.address_valid = 1'b0;
        bus.write = 1'b0;     bus.wdata = 8'h00;
        bus.ppu_ack = 1'b0;   bus.ppu_rdata = 8'h00;
        bus.prg_ack = 1'b0;   bus.prg_data = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        int edge_idx;

        drive_idle();
        b16.tick = 1'b0;     b16.address = 16'hC005; b16.address_valid = 1'b1;
        b16.write = 1'b0;    b16.wdata = 8'h00;
        b16.ppu_ack = 1'b0;  b16.ppu_rdata = 8'h00;
        b16.prg_ack = 1'b0;  b16.prg_data = 8'h00;
        bus.address = 16'hFFFC;

        // ---------------- reset state ----------------
        step();
        step();
        check("reset rdata",     {8'h00, bus.rdata},      16'h0000);
        check("reset valid",     {15'h0, bus.data_valid}, 16'h0000);
        check("reset prg_req",   {15'h0, bus.prg_request}, 16'h0000);
        check("reset ppu_strb",  {14'h0, bus.ppu_read, bus.ppu_write}, 16'h0000);
        check("reset prg_addr",  {1'b0, bus.prg_address}, 16'h0000);
        check("reset error",     {15'h0, bus.bus_error},  16'h0000);
        rst = 1'b0;

        // address_valid low: pending access must wait
        repeat (3) step();
        check("hold valid",   {15'h0, bus.data_valid},  16'h0000);
        check("hold prg_req", {15'h0, bus.prg_request}, 16'h0000);
        // 16 KiB mirror instance launched right after reset
        check("prg16 addr",   {1'b0, b16.prg_address},  16'h0005);
        check("prg16 req",    {15'h0, b16.prg_request}, 16'h0001);

        // ---------------- table-driven vectors ----------------
        //          t av wr addr       wd     pack prd    gack grd     rdata  v  rd wr pa    gr ga         err
        vecs.push_back(mk(0,1,0,16'hFFFC,8'h00, 0,8'h00, 0,8'h00, 8'h00,0,0,0,3'd0, 1,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'hFFFC,8'h00, 0,8'h00, 0,8'h00, 8'h00,0,0,0,3'd0, 1,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'hFFFC,8'h00, 0,8'h00, 1,8'h34, 8'h34,1,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'hFFFC,8'h00, 0,8'h00, 0,8'h00, 8'h34,1,0,0,3'd0, 0,15'h7FFC,0));
        // RAM write $5A to $0801
        vecs.push_back(mk(1,1,1,16'h0801,8'h5A, 0,8'h00, 0,8'h00, 8'h34,1,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,1,16'h0801,8'h5A, 0,8'h00, 0,8'h00, 8'h34,0,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,1,16'h0801,8'h5A, 0,8'h00, 0,8'h00, 8'h5A,1,0,0,3'd0, 0,15'h7FFC,0));
        // PPU write $80 to $2000, ack one cycle after request
        vecs.push_back(mk(1,1,1,16'h2000,8'h80, 0,8'h00, 0,8'h00, 8'h5A,1,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,1,16'h2000,8'h80, 0,8'h00, 0,8'h00, 8'h5A,0,0,1,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,1,16'h2000,8'h80, 1,8'h00, 0,8'h00, 8'h80,1,0,0,3'd0, 0,15'h7FFC,0));
        // RAM mirror read $1801
        vecs.push_back(mk(1,1,0,16'h1801,8'h00, 0,8'h00, 0,8'h00, 8'h80,1,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'h1801,8'h00, 0,8'h00, 0,8'h00, 8'h80,0,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'h1801,8'h00, 0,8'h00, 0,8'h00, 8'h5A,1,0,0,3'd0, 0,15'h7FFC,0));
        // PPU read $3FFA; ack already high at launch must be ignored
        vecs.push_back(mk(1,1,0,16'h3FFA,8'h00, 0,8'h00, 0,8'h00, 8'h5A,1,0,0,3'd0, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'h3FFA,8'h00, 1,8'hC3, 0,8'h00, 8'h5A,0,1,0,3'd2, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'h3FFA,8'h00, 1,8'hC3, 0,8'h00, 8'hC3,1,0,0,3'd2, 0,15'h7FFC,0));
        // PRG read $A000 returns $A9
        vecs.push_back(mk(1,1,0,16'hA000,8'h00, 0,8'h00, 0,8'h00, 8'hC3,1,0,0,3'd2, 0,15'h7FFC,0));
        vecs.push_back(mk(0,1,0,16'hA000,8'h00, 0,8'h00, 0,8'h00, 8'hC3,0,0,0,3'd2, 1,15'h2000,0));
        vecs.push_back(mk(0,1,0,16'hA000,8'h00, 0,8'h00, 1,8'hA9, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        // unmapped read $4017: open bus, valid at T+2
        vecs.push_back(mk(1,1,0,16'h4017,8'h00, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,0,16'h4017,8'h00, 0,8'h00, 0,8'h00, 8'hA9,0,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,0,16'h4017,8'h00, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        // PRG write $8000: discarded, no request
        vecs.push_back(mk(1,1,1,16'h8000,8'h11, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,1,16'h8000,8'h11, 0,8'h00, 0,8'h00, 8'hA9,0,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,1,16'h8000,8'h11, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        // unmapped write $5000: discarded
        vecs.push_back(mk(1,1,1,16'h5000,8'h22, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,1,16'h5000,8'h22, 0,8'h00, 0,8'h00, 8'hA9,0,0,0,3'd2, 0,15'h2000,0));
        vecs.push_back(mk(0,1,1,16'h5000,8'h22, 0,8'h00, 0,8'h00, 8'hA9,1,0,0,3'd2, 0,15'h2000,0));

        foreach (vecs[i]) begin
            bus.tick = vecs[i].tick;       bus.address_valid = vecs[i].av;
            bus.write = vecs[i].wr;        bus.address = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            bus.ppu_ack = vecs[i].ppu_ack; bus.ppu_rdata = vecs[i].ppu_rdata;
            bus.prg_ack = vecs[i].prg_ack; bus.prg_data = vecs[i].prg_data;
            step();
            check($sformatf("v%0d rdata", i),    {8'h00, bus.rdata},        {8'h00, vecs[i].e_rdata});
            check($sformatf("v%0d valid", i),    {15'h0, bus.data_valid},   {15'h0, vecs[i].e_valid});
            check($sformatf("v%0d ppu_rd", i),   {15'h0, bus.ppu_read},     {15'h0, vecs[i].e_ppu_rd});
            check($sformatf("v%0d ppu_wr", i),   {15'h0, bus.ppu_write},    {15'h0, vecs[i].e_ppu_wr});
            check($sformatf("v%0d ppu_addr", i), {13'h0, bus.ppu_addr},     {13'h0, vecs[i].e_ppu_addr});
            check($sformatf("v%0d prg_req", i),  {15'h0, bus.prg_request},  {15'h0, vecs[i].e_prg_req});
            check($sformatf("v%0d prg_addr", i), {1'b0, bus.prg_address},   {1'b0, vecs[i].e_prg_addr});
            check($sformatf("v%0d error", i),    {15'h0, bus.bus_error},    {15'h0, vecs[i].e_err});
        end
        drive_idle();
        bus.address_valid = 1'b1;

        // ---------------- PRG timeout at $FFFF ----------------
        bus.tick = 1'b1; bus.address = 16'hFFFF; bus.write = 1'b0;
        step();                                   // edge T
        bus.tick = 1'b0;
        step();                                   // edge T+1: launch
        check("to prg_addr", {1'b0, bus.prg_address}, 16'h7FFF);
        check("to req",      {15'h0, bus.prg_request}, 16'h0001);
        n_req    = 1;
        edge_idx = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            edge_idx++;
            if (!bus.prg_request) break;
            n_req++;
        end
        check("to req cycles", 16'(n_req),    16'd8);
        check("to valid edge", 16'(edge_idx), 16'd9);
        check("to valid",      {15'h0, bus.data_valid}, 16'h0001);
        check("to rdata",      {8'h00, bus.rdata},      16'h00A9);
        check("to error",      {15'h0, bus.bus_error},  16'h0001);

        // ---------------- reset during a PRG wait ----------------
        bus.tick = 1'b1; bus.address = 16'h8005;
        step();
        bus.tick = 1'b0;
        step();
        check("rw prg_req", {15'h0, bus.prg_request}, 16'h0001);
        step();
        rst = 1'b1;
        bus.address_valid = 1'b0;
        step();
        check("rw req after rst",   {15'h0, bus.prg_request}, 16'h0000);
        check("rw error after rst", {15'h0, bus.bus_error},   16'h0000);
        check("rw valid after rst", {15'h0, bus.data_valid},  16'h0000);
        rst = 1'b0;

        // ---------------- overlapping tick ----------------
        bus.address = 16'h9000; bus.address_valid = 1'b1;
        step();                                   // launch from reset-pending
        check("ov prg_addr", {1'b0, bus.prg_address}, 16'h1000);
        step();
        bus.tick = 1'b1; bus.address = 16'h2001;
        step();                                   // tick lands mid-wait
        bus.tick = 1'b0;
        check("ov req dropped", {15'h0, bus.prg_request}, 16'h0000);
        check("ov error",       {15'h0, bus.bus_error},   16'h0001);
        check("ov valid",       {15'h0, bus.data_valid},  16'h0000);
        step();                                   // new address launches
        check("ov ppu_rd",   {15'h0, bus.ppu_read}, 16'h0001);
        check("ov ppu_addr", {13'h0, bus.ppu_addr}, 16'h0001);
        bus.ppu_ack = 1'b1; bus.ppu_rdata = 8'h77;
        step();
        bus.ppu_ack = 1'b0;
        check("ov rdata",        {8'h00, bus.rdata},     16'h0077);
        check("ov error sticky", {15'h0, bus.bus_error}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
